// File: rtl/csa_serial_add_ctrl.sv
// csa_serial_add_ctrl
//
// Computes a WIDTH-bit add or subtract one nibble per clock, LSB nibble first,
// using a single 4-bit carry-select adder. The ripple carry is held in a
// register between nibble steps. Subtraction is a + ~b + 1.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only while idle
//   op     0 = add (a + b + c_in), 1 = subtract (a - b)
//   a, b   operands, captured when start is accepted
//   c_in   carry-in for add, ignored for subtract
//   busy   high while an operation is in flight (ADD and DONE states)
//   done   one-cycle pulse, sum/c_out valid
//   sum    registered result
//   c_out  final carry; for subtract 1 = no borrow (a >= b unsigned)

module csa_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              carry_q, c_out_q, busy_q, done_q;
    logic [IDX_W-1:0]  idx_q;

    // 4-bit carry-select adder: low pair ripples, high pair is precomputed
    // for both carry values and selected by the low-pair carry.
    logic [3:0] nib_a, nib_b, nib_s;
    logic       nib_co;
    logic [2:0] lo_sum, hi_sum0, hi_sum1, hi_sel;

    always_comb begin
        nib_a   = a_q[{idx_q, 2'b00} +: 4];
        nib_b   = b_q[{idx_q, 2'b00} +: 4];
        lo_sum  = 3'(nib_a[1:0]) + 3'(nib_b[1:0]) + 3'(carry_q);
        hi_sum0 = 3'(nib_a[3:2]) + 3'(nib_b[3:2]);
        hi_sum1 = 3'(nib_a[3:2]) + 3'(nib_b[3:2]) + 3'd1;
        hi_sel  = lo_sum[2] ? hi_sum1 : hi_sum0;
        nib_s   = {hi_sel[1:0], lo_sum[1:0]};
        nib_co  = hi_sel[2];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StAdd;
            StAdd:   if (idx_q == LAST_IDX) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Outputs are registered from the next state so start has no
            // combinational path to busy/done.
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= op ? ~b : b;
                        carry_q <= op | c_in;
                        idx_q   <= '0;
                    end
                end
                StAdd: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= nib_s;
                    carry_q                    <= nib_co;
                    if (idx_q == LAST_IDX) begin
                        c_out_q <= nib_co;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_csa_serial_add_ctrl.sv
// Self-checking bench for csa_serial_add_ctrl: a 16-bit instance for directed,
// timing and random checks, and a 4-bit instance for an exhaustive add sweep.

module tb_csa_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        start16, op16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, c_out16;
    logic [15:0] sum16;

    logic        start4, op4, cin4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, c_out4;
    logic [3:0]  sum4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csa_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
        .clk  (clk),
        .rst  (rst),
        .start(start16),
        .op   (op16),
        .a    (a16),
        .b    (b16),
        .c_in (cin16),
        .busy (busy16),
        .done (done16),
        .sum  (sum16),
        .c_out(c_out16)
    );

    csa_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .start(start4),
        .op   (op4),
        .a    (a4),
        .b    (b4),
        .c_in (cin4),
        .busy (busy4),
        .done (done4),
        .sum  (sum4),
        .c_out(c_out4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request on the 16-bit DUT and follows it until busy drops.
    // done_edge counts edges after the acceptance edge.
    task automatic run16(input logic o, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, output logic [15:0] s, output logic co,
                         output int done_edge, output int ndone, output int nbusy);
        op16 = o; a16 = x; b16 = y; cin16 = ci; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        // Operand changes while busy must not matter.
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = ~ci; op16 = ~o;
        nbusy = busy16 ? 1 : 0;
        ndone = 0; done_edge = -1; s = '0; co = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done16) begin
                ndone++; done_edge = k; s = sum16; co = c_out16;
            end
            if (busy16) nbusy++;
            else break;
        end
    endtask

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        co;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] s, exp_s;
        logic        co, exp_co, o, ci;
        logic [16:0] wide;
        logic [15:0] x, y;
        logic [4:0]  ref4;
        int          de, nd, nb, k;

        vecs[0] = '{op: 1'b0, a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, co: 1'b1};
        vecs[1] = '{op: 1'b0, a: 16'h1234, b: 16'h4321, cin: 1'b1, sum: 16'h5556, co: 1'b0};
        vecs[2] = '{op: 1'b1, a: 16'h1234, b: 16'h0234, cin: 1'b0, sum: 16'h1000, co: 1'b1};
        vecs[3] = '{op: 1'b1, a: 16'h0000, b: 16'h0001, cin: 1'b0, sum: 16'hFFFF, co: 1'b0};
        vecs[4] = '{op: 1'b1, a: 16'h0005, b: 16'h0003, cin: 1'b1, sum: 16'h0002, co: 1'b1};

        rst = 1'b1;
        start16 = 0; op16 = 0; cin16 = 0; a16 = '0; b16 = '0;
        start4 = 0; op4 = 0; cin4 = 0; a4 = '0; b4 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("por_busy", 32'(busy16), 0);
        check("por_done", 32'(done16), 0);
        check("por_sum", 32'(sum16), 0);
        check("por_cout", 32'(c_out16), 0);
        check("por_busy4", 32'(busy4), 0);

        // Directed table: result plus latency and pulse shape.
        foreach (vecs[i]) begin
            run16(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, s, co, de, nd, nb);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].co));
            check($sformatf("vec%0d_done_edge", i), 32'(de), 4);
            check($sformatf("vec%0d_ndone", i), 32'(nd), 1);
            check($sformatf("vec%0d_busy_cycles", i), 32'(nb), 5);
        end
        // Result holds while idle.
        repeat (2) tick();
        check("hold_sum", 32'(sum16), 32'h0002);
        check("hold_cout", 32'(c_out16), 1);
        check("hold_done", 32'(done16), 0);

        // Random operations against an arithmetic model.
        for (int i = 0; i < 40; i++) begin
            o  = 1'($urandom);
            ci = 1'($urandom);
            x  = 16'($urandom);
            y  = 16'($urandom);
            if (o) begin
                exp_s  = x - y;
                exp_co = (x >= y);
            end else begin
                wide   = 17'(x) + 17'(y) + 17'(ci);
                exp_s  = wide[15:0];
                exp_co = wide[16];
            end
            run16(o, x, y, ci, s, co, de, nd, nb);
            check($sformatf("rnd%0d_sum", i), 32'(s), 32'(exp_s));
            check($sformatf("rnd%0d_cout", i), 32'(co), 32'(exp_co));
            check($sformatf("rnd%0d_ndone", i), 32'(nd), 1);
        end

        // Busy protection: second request two cycles later is dropped.
        op16 = 0; cin16 = 0; a16 = 16'h00FF; b16 = 16'h0001; start16 = 1;
        tick();
        start16 = 0;
        tick();
        tick();
        a16 = 16'hAAAA; b16 = 16'h5555; start16 = 1;
        tick();
        start16 = 0;
        nd = 0; s = '0; co = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (done16) begin
                nd++; s = sum16; co = c_out16;
            end
            if (!busy16) break;
            tick();
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            if (done16) nd++;
        end
        check("busyprot_sum", 32'(s), 32'h0100);
        check("busyprot_cout", 32'(co), 0);
        check("busyprot_ndone", 32'(nd), 1);
        check("busyprot_idle", 32'(busy16), 0);

        // Reset after random activity: mid-operation reset held 2 cycles.
        op16 = 0; cin16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); start16 = 1;
        tick();
        start16 = 0;
        tick();
        rst = 1;
        tick();
        tick();
        check("rst_busy", 32'(busy16), 0);
        check("rst_done", 32'(done16), 0);
        check("rst_sum", 32'(sum16), 0);
        check("rst_cout", 32'(c_out16), 0);
        rst = 0;
        nd = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (done16 || busy16 || sum16 != 0 || c_out16) nd++;
        end
        check("rst_idle_stable", 32'(nd), 0);

        // Reset after the 2nd ADD edge: no done pulse, sum cleared.
        op16 = 0; cin16 = 0; a16 = 16'h1111; b16 = 16'h2222; start16 = 1;
        tick();
        start16 = 0;
        tick();
        tick();
        check("midop_partial_sum", 32'(sum16 != 0), 1);
        rst = 1;
        tick();
        rst = 0;
        check("midop_sum", 32'(sum16), 0);
        check("midop_busy", 32'(busy16), 0);
        nd = 0;
        for (int j = 0; j < 6; j++) begin
            if (done16) nd++;
            tick();
        end
        check("midop_no_done", 32'(nd), 0);
        run16(1'b0, 16'h0F0F, 16'h0101, 1'b0, s, co, de, nd, nb);
        check("after_rst_sum", 32'(s), 32'h1010);
        check("after_rst_cout", 32'(co), 0);
        check("after_rst_ndone", 32'(nd), 1);

        // Exhaustive WIDTH=4 add sweep, one transaction every 3 cycles.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); op4 = 0; start4 = 1;
                    tick();
                    start4 = 0;
                    ref4 = 5'(ia + ib + ic);
                    k = 0;
                    while (!done4 && k < 5) begin
                        tick();
                        k++;
                    end
                    check($sformatf("sweep_%0h_%0h_%0d", ia, ib, ic),
                          32'({c_out4, sum4, 4'(k)}), 32'({ref4, 4'd1}));
                    tick();
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
